// File: rtl/fifo_byte_reader_pkg.sv
// Shared constants, state type and sizing helper for the FIFO byte reader.
package fifo_byte_reader_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        StEmpty,
        StHold
    } rd_state_e;

    // Byte index width; a single-byte word still needs a 1-bit counter.
    function automatic int unsigned calc_idx_w(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_reader_if.sv
// FIFO read port plus byte-stream handshake; master is the reader, slave the environment.
interface fifo_byte_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_ren;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic                  out_last;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  out_ready,
        output fifo_ren,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output out_ready,
        input  fifo_ren,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/fifo_byte_reader_mux.sv
// Pure byte-lane selector: picks byte i_idx (or its mirror when MSB_FIRST) out of i_word.
module fifo_byte_reader_mux
    import fifo_byte_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [IDX_W-1:0]      i_idx,
    output logic [BYTE_W-1:0]     o_byte
);

    localparam int unsigned NB = DATA_WIDTH / BYTE_W;

    logic [IDX_W-1:0] w_lane;

    always_comb begin
        w_lane = MSB_FIRST ? (IDX_W'(NB - 1) - i_idx) : i_idx;
        o_byte = i_word[BYTE_W * w_lane +: BYTE_W];
    end

endmodule

// File: rtl/fifo_byte_reader.sv
// Drains words from a first-word-fall-through FIFO and emits them one byte per clock.
module fifo_byte_reader
    import fifo_byte_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_flush,
    fifo_byte_reader_if.master bus,
    output logic               o_busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_W;
    localparam int unsigned IDX_W = calc_idx_w(NB);

    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH < BYTE_W) begin : g_width_check
        $error("fifo_byte_reader: DATA_WIDTH must be a non-zero multiple of 8");
    end

    rd_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]      r_idx;

    logic w_word_valid;
    logic w_last;
    logic w_accept;
    logic w_ren;

    always_comb begin
        w_word_valid = (r_state == StHold);
        w_last       = (r_idx == IDX_W'(NB - 1));
        w_accept     = bus.out_valid & bus.out_ready;
        // Pop on empty holder, or in the same cycle the final byte leaves (no bubble).
        w_ren        = i_arst_n & ~bus.fifo_empty & ~i_flush
                     & (~w_word_valid | (bus.out_ready & w_last));
    end

    assign bus.fifo_ren  = w_ren;
    assign bus.out_valid = w_word_valid & ~i_flush;
    assign bus.out_last  = w_word_valid & w_last;
    assign o_busy        = w_word_valid | w_ren;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= StEmpty;
            r_word  <= '0;
            r_idx   <= '0;
        end else if (i_flush) begin
            r_state <= StEmpty;
            r_idx   <= '0;
        end else if (w_ren) begin
            r_state <= StHold;
            r_word  <= bus.fifo_rdata;
            r_idx   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= StEmpty;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    fifo_byte_reader_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_mux (
        .i_word(r_word),
        .i_idx (r_idx),
        .o_byte(bus.out_data)
    );

endmodule

// File: doc/fifo_byte_reader.md
# fifo_byte_reader

Read-side drain engine for the housekeeper's synchronous FIFO. It pops DATA_WIDTH-bit words from a first-word-fall-through FIFO and emits them as a byte stream on a valid/ready interface. Each word is emitted least-significant byte first by default, and the last byte of each word is tagged. It sits between the FIFO read port and byte-oriented consumers such as the SPI/UART transmit path, and it sustains one byte per clock.

## Interface
- DATA_WIDTH, 32: FIFO word width; must be a multiple of 8, minimum 8.
- MSB_FIRST, 0: 1 emits the most-significant byte first.
- Clk  in  1  clock; all logic is on the rising edge.
- ARstN  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous discard of the word currently held; the FIFO is not touched.
- FifoEmpty  in  1  FIFO empty flag.
- FifoRData  in  DATA_WIDTH  FIFO head word; valid whenever FifoEmpty=0.
- FifoRen  out  1  pop strobe; the head is consumed at the clock edge.
- OutValid  out  1  OutData holds a valid byte.
- OutReady  in  1  consumer accepts the byte at the clock edge when OutValid=1.
- OutData  out  8  byte lane.
- OutLast  out  1  current byte is the final byte of its word.
- Busy  out  1  a word is held or being loaded (WordValid | FifoRen).

## Operation
- Definitions:
  - NB = DATA_WIDTH/8.
  - Registers: WordReg[DATA_WIDTH-1:0], WordValid, Idx[$clog2(NB)-1:0], with a minimum width of 1.
- Two states:
  - EMPTY: WordValid=0.
  - HOLD: WordValid=1.
- Handshake terms:
  - A byte is accepted when OutValid & OutReady.
  - Last = (Idx == NB-1).
- FifoRen = !FifoEmpty & !Flush & (!WordValid | (OutReady & Last)). It is combinational, and it is never asserted while FifoEmpty=1 or during reset.
- EMPTY → HOLD on FifoRen. The edge loads WordReg←FifoRData and sets Idx←0.
- HOLD, byte accepted, Idx<NB-1: Idx←Idx+1.
- HOLD, byte accepted, Last:
  - If FifoRen (back-to-back): reload WordReg, set Idx←0, stay in HOLD.
  - Otherwise: go to EMPTY.
- OutValid = WordValid & !Flush.
- OutData byte select:
  - MSB_FIRST=0: byte Idx of WordReg (bits 8*Idx+7:8*Idx).
  - MSB_FIRST=1: byte NB-1-Idx.
- OutLast = WordValid & Last.
- Flush=1:
  - At the next edge, WordValid←0 and Idx←0. A partially emitted word is discarded.
  - FifoRen is held low that cycle, so no word is popped.
  - Flush wins over a simultaneous accept.
- OutData and OutLast are stable while OutValid=1 and OutReady=0. This is an AXI-style hold rule; OutValid never drops without acceptance except on Flush.
- NB=1: every byte has OutLast=1, and the Idx counter is constant 0.

## Timing
- Reset values (ARstN low, asynchronous):
  - WordValid=0, Idx=0, WordReg=0.
  - Hence OutValid=0, OutLast=0, OutData=0, Busy=0 and FifoRen=0.
- Release from reset takes effect at the first rising edge with ARstN high.
- Latency: a word at the FIFO head while in EMPTY gives FifoRen=1 in the same cycle and OutValid=1 in the next cycle (1 cycle FIFO→first byte).
- Throughput:
  - With OutReady held high and the FIFO non-empty, one byte per cycle and no bubbles between words.
  - The pop for word k+1 coincides with acceptance of the last byte of word k.
- Backpressure: OutReady=0 freezes Idx and WordReg. No pop occurs while HOLD is stalled.
- FIFO goes empty mid-stream: the current word completes, then the block enters EMPTY with OutValid=0 until FifoEmpty deasserts.
- Reset asserted mid-word: the word is lost and the outputs clear immediately, asynchronously.

## Structure
- No shared package types are required.
- Local constants: NB and IDX_W = (NB>1) ? $clog2(NB) : 1.
- Optional sub-module fifo_byte_reader_mux: a pure byte-lane selector taking (WordReg, Idx, MSB_FIRST) and producing OutData. Everything else is inline.
- Elaboration-time check: DATA_WIDTH%8==0, else $error.

## Test plan
- Reset, then FIFO holding 0x44332211 with OutReady=1: FifoRen pulses in cycle 0, and bytes 0x11,0x22,0x33,0x44 appear in cycles 1-4 with OutLast only on 0x44; OutValid=0 in cycle 5.
- Two words, 0x44332211 then 0x88776655, queued with OutReady=1: eight consecutive bytes 0x11..0x88 with no gap, and FifoRen is high in the same cycle as the 0x44 acceptance.
- MSB_FIRST=1, word 0xAABBCCDD: output order 0xAA,0xBB,0xCC,0xDD, with OutLast on 0xDD.
- OutReady toggling 1,0,0,1,…: each byte is held stable while stalled, no byte is duplicated or skipped, and FifoRen never fires during a stall.
- Flush after 2 of 4 bytes: OutValid drops the next cycle and the remaining 2 bytes are discarded. With the FIFO non-empty, the next word starts at byte 0 one cycle after Flush deasserts.
- FifoEmpty=1 throughout, random OutReady: FifoRen=0 and OutValid=0 always. Asserting ARstN low mid-word clears OutValid and Busy without waiting for a clock.
